// File: rtl/lsu_queue_writer_if.sv
// rtl/lsu_queue_writer_if.sv - dispatch-to-queue drive/free handshake with instruction payload
interface lsu_queue_writer_if #(
    parameter int WIDTH = 113
);
    logic             i_DriveFromDispatch_1;
    logic             o_FreeToDispatch_1;
    logic [WIDTH-1:0] i_Instruction_113;

    modport master (
        output i_DriveFromDispatch_1,
        output i_Instruction_113,
        input  o_FreeToDispatch_1
    );

    modport slave (
        input  i_DriveFromDispatch_1,
        input  i_Instruction_113,
        output o_FreeToDispatch_1
    );
endinterface

// File: rtl/lsu_queue_writer.sv
// rtl/lsu_queue_writer.sv - write side of the LSU instruction queue with Gray pointer exchange
module lsu_queue_writer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 113
) (
    input  logic                              clk,
    input  logic                              rstn,
    lsu_queue_writer_if.slave                 dispatch,
    output logic [(1<<DEPTH_LOG2)*WIDTH-1:0]  o_InstructionToLSUIssue_1808,
    output logic [DEPTH_LOG2:0]               o_LSUCount_5,
    input  logic [DEPTH_LOG2:0]               i_LSUReadPtr_5,
    output logic                              o_Empty_1,
    output logic                              o_IsFirst_1,
    output logic                              o_Full_1,
    output logic [DEPTH_LOG2:0]               o_Occupancy_5
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wbin;
    logic [PW-1:0]    rgraySync1;
    logic [PW-1:0]    rgraySync;
    logic [PW-1:0]    rbin;
    logic [PW-1:0]    wbinNext;
    logic [PW-1:0]    wgrayNext;
    logic [PW-1:0]    occNext;
    logic             freeReg;
    logic             accept;
    logic             fullMatch;

    assign dispatch.o_FreeToDispatch_1 = freeReg;

    always_comb begin
        accept    = dispatch.i_DriveFromDispatch_1 & freeReg;
        wbinNext  = wbin + PW'(accept);
        wgrayNext = wbinNext ^ (wbinNext >> 1);
        // Gray-to-binary as an XOR of all right shifts avoids a bitwise self-referencing chain.
        rbin = rgraySync;
        for (int i = 1; i < PW; i++) begin
            rbin = rbin ^ (rgraySync >> i);
        end
        occNext   = wbinNext - rbin;
        fullMatch = (wgrayNext == {~rgraySync[PW-1:PW-2], rgraySync[PW-3:0]});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            wbin          <= '0;
            o_LSUCount_5  <= '0;
            rgraySync1    <= '0;
            rgraySync     <= '0;
            freeReg       <= 1'b1;
            o_Full_1      <= 1'b0;
            o_Empty_1     <= 1'b1;
            o_IsFirst_1   <= 1'b0;
            o_Occupancy_5 <= '0;
        end else begin
            rgraySync1 <= i_LSUReadPtr_5;
            rgraySync  <= rgraySync1;
            // Entry and pointer move on the same edge, so data is settled before the count is seen.
            if (accept) begin
                mem[wbin[DEPTH_LOG2-1:0]] <= dispatch.i_Instruction_113;
            end
            wbin          <= wbinNext;
            o_LSUCount_5  <= wgrayNext;
            o_Full_1      <= fullMatch;
            freeReg       <= !fullMatch;
            o_Empty_1     <= (wgrayNext == rgraySync);
            o_IsFirst_1   <= (occNext == PW'(1));
            o_Occupancy_5 <= occNext;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flatten
        assign o_InstructionToLSUIssue_1808[k*WIDTH +: WIDTH] = mem[k];
    end
endmodule

// File: tb/tb_lsu_queue_writer.sv
// tb/tb_lsu_queue_writer.sv - randomized self-checking bench for lsu_queue_writer
module tb_lsu_queue_writer;
    localparam int W = 113;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N*W-1:0] arr;
    logic [4:0]   count;
    logic [4:0]   rptr = '0;
    logic [4:0]   occ;
    logic         empty, first, full;

    always #5 clk = ~clk;

    lsu_queue_writer_if #(.WIDTH(W)) dif ();

    lsu_queue_writer #(.DEPTH_LOG2(4), .WIDTH(W)) dut (
        .clk                          (clk),
        .rstn                         (rstn),
        .dispatch                     (dif.slave),
        .o_InstructionToLSUIssue_1808 (arr),
        .o_LSUCount_5                 (count),
        .i_LSUReadPtr_5               (rptr),
        .o_Empty_1                    (empty),
        .o_IsFirst_1                  (first),
        .o_Full_1                     (full),
        .o_Occupancy_5                (occ)
    );

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: entry contents, total writes mod 32, and read pointer samples per edge.
    logic [W-1:0] mMem [N];
    int mWr, mOcc, p1, p2;

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < 5; s++) b = b ^ (g >> s);
        return b & 31;
    endfunction

    function automatic logic [4:0] b2g(input int b);
        return 5'(b ^ (b >> 1));
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic logic [N*W-1:0] expArr();
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = mMem[k];
        return f;
    endfunction

    function automatic logic [13:0] expSt();
        return {mOcc != 16, mOcc == 16, mOcc == 0, mOcc == 1, 5'(mOcc), b2g(mWr)};
    endfunction

    function automatic logic [13:0] dutSt();
        return {dif.o_FreeToDispatch_1, full, empty, first, occ, count};
    endfunction

    task automatic modelReset();
        for (int k = 0; k < N; k++) mMem[k] = '0;
        mWr = 0; mOcc = 0; p1 = 0; p2 = 0;
    endtask

    task automatic cycle(input logic drv, input logic [W-1:0] d, input logic [4:0] rp);
        @(negedge clk);
        dif.i_DriveFromDispatch_1 = drv;
        dif.i_Instruction_113     = d;
        rptr                      = rp;
        @(posedge clk);
        if (drv && mOcc != 16) begin
            mMem[mWr % 16] = d;
            mWr = (mWr + 1) % 32;
        end
        // Status at this edge sees the read pointer that was sampled two edges earlier.
        mOcc = (mWr - g2b(p2)) & 31;
        p2 = p1;
        p1 = int'(rp);
        #1;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rstn = 1'b0;
        dif.i_DriveFromDispatch_1 = 1'b0;
        rptr = '0;
        modelReset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if (dutSt() !== expSt()) begin
            nFail++; $display("FAIL reset_status got=%h want=%h", dutSt(), expSt());
        end
        nChecks++;
        if (arr !== '0) begin
            nFail++; $display("FAIL reset_array got nonzero want zero");
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_write();
        cycle(1'b1, 113'h1_ABCD, 5'd0);
        nChecks++;
        if (arr[W-1:0] !== 113'h1_ABCD) begin
            nFail++; $display("FAIL single_entry0 got=%h want=%h", arr[W-1:0], 113'h1_ABCD);
        end
        nChecks++;
        if ({count, first, empty} !== {5'b00001, 1'b1, 1'b0}) begin
            nFail++; $display("FAIL single_status got=%b want=%b", {count, first, empty}, 7'b0000110);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, rnd(), 5'd0);
            nChecks++;
            if (dutSt() !== expSt()) begin
                nFail++; $display("FAIL fill_status[%0d] got=%h want=%h", i, dutSt(), expSt());
            end
        end
        nChecks++;
        if ({full, occ, count} !== {1'b1, 5'd16, 5'b11000}) begin
            nFail++; $display("FAIL fill_full got=%b want=%b", {full, occ, count}, 11'b11000011000);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rnd(), 5'd0);
            nChecks++;
            if (arr[W-1:0] !== 113'h1_ABCD || count !== 5'b11000 || dif.o_FreeToDispatch_1 !== 1'b0) begin
                nFail++; $display("FAIL fill_stall[%0d] entry0=%h count=%b free=%b want entry0=1abcd count=11000 free=0",
                                  i, arr[W-1:0], count, dif.o_FreeToDispatch_1);
            end
        end
    endtask

    task automatic test_drain_release();
        logic [W-1:0] d;
        d = rnd();
        for (int e = 1; e <= 3; e++) begin
            cycle(1'b1, d, 5'b00001);
            nChecks++;
            if (dif.o_FreeToDispatch_1 !== (e == 3)) begin
                nFail++; $display("FAIL drain_free_edge%0d got=%b want=%b", e, dif.o_FreeToDispatch_1, e == 3);
            end
        end
        cycle(1'b1, d, 5'b00001);
        nChecks++;
        if (arr[W-1:0] !== d || count !== 5'b11001) begin
            nFail++; $display("FAIL drain_accept entry0=%h count=%b want entry0=%h count=11001", arr[W-1:0], count, d);
        end
        nChecks++;
        if (dutSt() !== expSt()) begin
            nFail++; $display("FAIL drain_status got=%h want=%h", dutSt(), expSt());
        end
        cycle(1'b0, '0, 5'b00001);
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        pulseReset();
        for (int i = 0; i < 40; i++) begin
            prev = count;
            cycle(1'b1, rnd(), b2g(mWr));
            nChecks++;
            if (dutSt() !== expSt() || arr !== expArr()) begin
                nFail++; $display("FAIL wrap_model[%0d] status got=%h want=%h", i, dutSt(), expSt());
            end
            nChecks++;
            if ($countones(count ^ prev) != 1 || full !== 1'b0) begin
                nFail++; $display("FAIL wrap_gray[%0d] prev=%b now=%b full=%b want one-bit step, full=0", i, prev, count, full);
            end
        end
    endtask

    task automatic test_random();
        int rb;
        pulseReset();
        rb = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1) == 1 && rb != mWr) rb = (rb + 1) % 32;
            cycle(1'($urandom_range(3) != 0), rnd(), b2g(rb));
            nChecks++;
            if (dutSt() !== expSt() || arr !== expArr()) begin
                nFail++; $display("FAIL random_model[%0d] status got=%h want=%h", i, dutSt(), expSt());
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd(), 5'd0);
        @(negedge clk);
        dif.i_DriveFromDispatch_1 = 1'b1;
        dif.i_Instruction_113 = rnd();
        #2 rstn = 1'b0;
        modelReset();
        #1;
        nChecks++;
        if (dutSt() !== expSt() || arr !== '0) begin
            nFail++; $display("FAIL midreset_async got=%h want=%h", dutSt(), expSt());
        end
        @(posedge clk);
        #1;
        nChecks++;
        if (count !== 5'd0 || arr !== '0) begin
            nFail++; $display("FAIL midreset_drop count=%b want=00000", count);
        end
        @(negedge clk);
        dif.i_DriveFromDispatch_1 = 1'b0;
        rstn = 1'b1;
        cycle(1'b0, '0, 5'd0);
        nChecks++;
        if (dutSt() !== expSt()) begin
            nFail++; $display("FAIL midreset_after got=%h want=%h", dutSt(), expSt());
        end
    endtask

    initial begin
        dif.i_DriveFromDispatch_1 = 1'b0;
        dif.i_Instruction_113     = '0;
        test_reset();
        test_single_write();
        test_fill();
        test_drain_release();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
